// File: rtl/sync_up_down_counter_n_pkg.sv
// sync_up_down_counter_n_pkg: direction and boundary-mode encodings shared by counter blocks and benches.
package sync_up_down_counter_n_pkg;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;
endpackage

// File: rtl/sync_up_down_counter_n_next_state.sv
// sync_up_down_counter_n_next_state: combinational next count, terminal count and wrap-pulse terms.
module sync_up_down_counter_n_next_state
    import sync_up_down_counter_n_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = longint'(1) << WIDTH,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_sel,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_tc,
    output logic             o_wrap_next
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic             SAT = (SATURATE == MODE_SAT);

    logic             w_at_top;
    logic             w_at_bot;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_ld;

    assign w_at_top    = (i_q == MAX);
    assign w_at_bot    = (i_q == '0);
    assign o_tc        = (i_sel == DIR_UP) ? w_at_top : w_at_bot;
    assign w_up        = w_at_top ? (SAT ? i_q : '0) : i_q + 1'b1;
    assign w_dn        = w_at_bot ? (SAT ? i_q : MAX) : i_q - 1'b1;
    // out-of-range load values clamp to the top of the count range
    assign w_ld        = (i_d > MAX) ? MAX : i_d;
    assign o_q_next    = i_load ? w_ld : !i_en ? i_q : (i_sel == DIR_DOWN) ? w_dn : w_up;
    assign o_wrap_next = i_en & o_tc & ~i_load;
endmodule

// File: rtl/sync_up_down_counter_n.sv
// sync_up_down_counter_n: parametrised up/down counter with load, wrap/saturate mode, tc and wrap pulse.
module sync_up_down_counter_n
    import sync_up_down_counter_n_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = longint'(1) << WIDTH,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("sync_up_down_counter_n: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;

    sync_up_down_counter_n_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .SATURATE(SATURATE)
    ) u_next (
        .i_q        (r_q),
        .i_sel      (sel),
        .i_en       (en),
        .i_load     (load),
        .i_d        (d),
        .o_q_next   (w_q_next),
        .o_tc       (tc),
        .o_wrap_next(w_wrap_next)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign Q    = r_q;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_sync_up_down_counter_n.sv
// tb_sync_up_down_counter_n: directed and random checks of four counter configurations against an arithmetic model.
module tb_sync_up_down_counter_n;
    logic       clk = 1'b0;
    logic       clr [3];
    logic       ld  [3];
    logic       en  [3];
    logic       sel [3];
    int         dv  [3];
    logic [2:0] q0, q1;
    logic [3:0] q2;
    logic       tc  [3];
    logic       wr  [3];
    logic       cclr, cen, ct0, ct1, cw0, cw1;
    logic [1:0] cq0, cq1;
    logic       w_ce1;
    int         mq [3];
    int         mw [3];
    int         mm [3] = '{8, 6, 16};
    bit         ms [3] = '{1'b0, 1'b0, 1'b1};
    int         cc;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    sync_up_down_counter_n #(.WIDTH(3)) dut0 (
        .clk(clk), .clear(clr[0]), .en(en[0]), .sel(sel[0]), .load(ld[0]), .d(3'(dv[0])),
        .Q(q0), .tc(tc[0]), .wrap(wr[0]));
    sync_up_down_counter_n #(.WIDTH(3), .MODULUS(6)) dut1 (
        .clk(clk), .clear(clr[1]), .en(en[1]), .sel(sel[1]), .load(ld[1]), .d(3'(dv[1])),
        .Q(q1), .tc(tc[1]), .wrap(wr[1]));
    sync_up_down_counter_n #(.WIDTH(4), .SATURATE(1)) dut2 (
        .clk(clk), .clear(clr[2]), .en(en[2]), .sel(sel[2]), .load(ld[2]), .d(4'(dv[2])),
        .Q(q2), .tc(tc[2]), .wrap(wr[2]));

    assign w_ce1 = cen & ct0;
    sync_up_down_counter_n #(.WIDTH(2)) cas0 (
        .clk(clk), .clear(cclr), .en(cen), .sel(1'b0), .load(1'b0), .d(2'd0),
        .Q(cq0), .tc(ct0), .wrap(cw0));
    sync_up_down_counter_n #(.WIDTH(2)) cas1 (
        .clk(clk), .clear(cclr), .en(w_ce1), .sel(1'b0), .load(1'b0), .d(2'd0),
        .Q(cq1), .tc(ct1), .wrap(cw1));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] oq [3];
        oq = '{32'(q0), 32'(q1), 32'(q2)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_q", i), oq[i], 32'(mq[i]));
            chk($sformatf("dut%0d_wrap", i), 32'(wr[i]), 32'(mw[i]));
            chk($sformatf("dut%0d_tc", i), 32'(tc[i]), 32'(sel[i] ? mq[i] == 0 : mq[i] == mm[i] - 1));
        end
        chk("cascade_q", 32'({cq1, cq0}), 32'(cc));
    endtask

    // model: unbounded step target, then fold into range by wrapping or clamping
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            int t;
            t = sel[i] ? mq[i] - 1 : mq[i] + 1;
            mw[i] = !clr[i] && !ld[i] && en[i] && (t < 0 || t >= mm[i]);
            if (clr[i]) mq[i] = 0;
            else if (ld[i]) mq[i] = (dv[i] < mm[i]) ? dv[i] : mm[i] - 1;
            else if (en[i]) mq[i] = ms[i] ? ((t < 0) ? 0 : (t >= mm[i]) ? mm[i] - 1 : t) : (t + mm[i]) % mm[i];
        end
        cc = cclr ? 0 : cen ? (cc + 1) % 16 : cc;
        check_all();
    endtask

    task automatic set(int i, logic c, logic l, logic e, logic s, int d);
        clr[i] = c;
        ld[i]  = l;
        en[i]  = e;
        sel[i] = s;
        dv[i]  = d;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            set(i, 1, 0, 0, 0, 0);
            mq[i] = 0;
            mw[i] = 0;
        end
        cclr = 1;
        cen  = 0;
        cc   = 0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) set(i, 0, 0, 0, 0, 0);
        cclr = 0;
        // up-count through roll-over
        set(0, 0, 0, 1, 0, 0);
        repeat (9) tick();
        // down-count and direction change
        set(0, 0, 1, 0, 0, 2);
        tick();
        set(0, 0, 0, 1, 1, 0);
        repeat (3) tick();
        sel[0] = 0;
        #1;
        check_all();
        tick();
        set(0, 0, 0, 0, 0, 0);
        // modulus 6
        set(1, 0, 0, 1, 0, 0);
        repeat (6) tick();
        set(1, 0, 0, 1, 1, 0);
        tick();
        set(1, 0, 1, 0, 0, 7);
        tick();
        set(1, 0, 0, 0, 0, 0);
        // saturate
        set(2, 0, 1, 0, 0, 14);
        tick();
        set(2, 0, 0, 1, 0, 0);
        repeat (4) tick();
        set(2, 0, 1, 0, 0, 1);
        tick();
        set(2, 0, 0, 1, 1, 0);
        repeat (2) tick();
        set(2, 0, 0, 0, 0, 0);
        // priority and mid-operation clear
        set(0, 0, 1, 0, 0, 5);
        tick();
        set(0, 0, 1, 1, 0, 2);
        tick();
        set(0, 1, 1, 1, 0, 0);
        tick();
        set(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        // cascade
        cen = 1;
        repeat (16) tick();
        cen = 0;
        tick();
        // random
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++)
                set(i, $urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                    1'($urandom_range(1)), int'($urandom_range(mm[i] == 16 ? 15 : 7)));
            cclr = $urandom_range(49) == 0;
            cen  = $urandom_range(3) != 0;
            if ($urandom_range(4) == 0) begin
                #2;
                sel[0] = ~sel[0];
                #1;
                check_all();
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
